// File: rtl/mudv_pkg.sv
// Shared definitions for the MUDV multiply/divide responder: op encodings,
// move-to / move-from select encodings, default latencies and FSM states.
package mudv_pkg;

  typedef enum logic [1:0] {
    MUDV_MULT  = 2'b00,
    MUDV_MULTU = 2'b01,
    MUDV_DIV   = 2'b10,
    MUDV_DIVU  = 2'b11
  } mudv_op_e;

  // wen bits: [1] writes HI, [0] writes LO
  localparam logic [1:0] MUDV_WEN_HI = 2'b10;
  localparam logic [1:0] MUDV_WEN_LO = 2'b01;

  // ressrc selects
  localparam logic [1:0] MUDV_RES_HI = 2'b10;
  localparam logic [1:0] MUDV_RES_LO = 2'b01;

  localparam int unsigned MUDV_MUL_LAT = 5;
  localparam int unsigned MUDV_DIV_LAT = 10;
  localparam int unsigned MUDV_CNT_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mudv_state_e;

  // Two's-complement negate when n is set
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mudv_if.sv
// Command/result bundle between the main controller (master) and the MUDV
// responder (slave).
interface mudv_if;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  wen;
  logic [1:0]  ressrc;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        busy;
  logic [31:0] res;

  modport master (
    output start, op, wen, ressrc, a, b, kill,
    input  busy, res
  );

  modport slave (
    input  start, op, wen, ressrc, a, b, kill,
    output busy, res
  );
endinterface

// File: rtl/mudv_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing {hi,lo}.
// Optional feature macro: MUDV_DIVZERO_HOLD_EN -- divide by zero raises
// 'hold' so the caller leaves HI/LO untouched; otherwise it yields
// LO=0xFFFFFFFF, HI=a.
module mudv_arith
  import mudv_pkg::*;
(
  input  mudv_op_e    op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hold
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Operand conditioning, multiply and magnitude divide. Signed divide works on
  // magnitudes so 0x80000000 / -1 wraps back to 0x80000000 with no special case;
  // a zero divisor is swapped for 1 to keep the quotient free of X.
  always_comb begin
    a_ext   = (op == MUDV_MULT) ? {{32{a[31]}}, a} : {32'b0, a};
    b_ext   = (op == MUDV_MULT) ? {{32{b[31]}}, b} : {32'b0, b};
    prod    = a_ext * b_ext;
    a_neg   = (op == MUDV_DIV) & a[31];
    b_neg   = (op == MUDV_DIV) & b[31];
    a_mag   = neg_if(a, a_neg);
    b_mag   = neg_if(b, b_neg);
    divisor = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
  end

  // Result selection including the divide-by-zero rule
  always_comb begin
    hi   = '0;
    lo   = '0;
    hold = 1'b0;
    case (op)
      MUDV_MULT, MUDV_MULTU: begin
        hi = prod[63:32];
        lo = prod[31:0];
      end
      default: begin
        if (b == '0) begin
`ifdef MUDV_DIVZERO_HOLD_EN
          hold = 1'b1;
`else
          hi = a;
          lo = '1;
`endif
        end else begin
          lo = neg_if(q_mag, a_neg ^ b_neg);
          hi = neg_if(r_mag, a_neg);
        end
      end
    endcase
  end

endmodule

// File: rtl/mudv.sv
// MUDV responder: owns HI/LO, runs fixed-latency multiply/divide, serves
// move-to/move-from. Optional feature macro: MUDV_DIVZERO_HOLD_EN (see
// mudv_arith).
module mudv
  import mudv_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUDV_MUL_LAT,
  parameter int unsigned DIV_LAT = MUDV_DIV_LAT
) (
  input  logic  clk,
  input  logic  reset,
  mudv_if.slave bus
);

  mudv_state_e           state_q, state_d;
  logic [MUDV_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           pend_hi_q, pend_hi_d;
  logic [31:0]           pend_lo_q, pend_lo_d;
  logic                  pend_hold_q, pend_hold_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;

  logic [31:0]           ar_hi;
  logic [31:0]           ar_lo;
  logic                  ar_hold;
  logic                  busy;
  logic                  accept;
  logic                  move_ok;
  logic [MUDV_CNT_W-1:0] lat_sel;

  // Result is computed from the operands present at accept and parked in the
  // pending registers, so later operand changes cannot disturb it.
  mudv_arith u_arith (
    .op   (mudv_op_e'(bus.op[1:0])),
    .a    (bus.a),
    .b    (bus.b),
    .hi   (ar_hi),
    .lo   (ar_lo),
    .hold (ar_hold)
  );

  assign busy     = (cnt_q != '0);
  assign bus.busy = busy;
  assign accept   = bus.start & ~bus.kill & ~busy;
  assign move_ok  = ~bus.kill & ~busy & ~bus.start;
  assign lat_sel  = bus.op[1] ? MUDV_CNT_W'(DIV_LAT) : MUDV_CNT_W'(MUL_LAT);

  // Next-state: accept/move-to in IDLE, count down and commit in RUN
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_hold_d = pend_hold_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_RUN;
          cnt_d       = lat_sel;
          pend_hi_d   = ar_hi;
          pend_lo_d   = ar_lo;
          pend_hold_d = ar_hold;
        end else if (move_ok) begin
          if ((bus.wen & MUDV_WEN_HI) != '0) hi_d = bus.a;
          if ((bus.wen & MUDV_WEN_LO) != '0) lo_d = bus.a;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - MUDV_CNT_W'(1);
        if (cnt_q == MUDV_CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!pend_hold_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, pending and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_hold_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_hold_q <= pend_hold_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  // Move-from mux over committed HI/LO only
  always_comb begin
    bus.res = '0;
    case (bus.ressrc)
      MUDV_RES_HI: bus.res = hi_q;
      MUDV_RES_LO: bus.res = lo_q;
      default:     bus.res = '0;
    endcase
  end

endmodule

// File: tb/tb_mudv.sv
// Randomized self-checking bench for mudv against a behavioural HI/LO model.
module tb_mudv;
  import mudv_pkg::*;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  logic clk;
  logic reset;
  mudv_if bus ();

  mudv #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: architectural result of one operation applied to the model
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      default: begin
        if (b == 0) begin
`ifndef MUDV_DIVZERO_HOLD_EN
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
`endif
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
    endcase
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    bus.ressrc = 2'b10; #1; h = bus.res;
    bus.ressrc = 2'b01; #1; l = bus.res;
    bus.ressrc = 2'b00; #1;
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] h, l;
    read_hilo(h, l);
    check({tag, "_hi"}, h, eh);
    check({tag, "_lo"}, l, el);
  endtask

  // disturb: 0 none, 1 second start mid-busy, 2 wen mid-busy, 3 kill mid-busy
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] wen_in, input int disturb);
    logic [31:0] oh, ol;
    int unsigned lat;
    oh  = m_hi;
    ol  = m_lo;
    lat = op[1] ? DIV_LAT : MUL_LAT;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = {1'($urandom_range(0, 1)), op};
    bus.a     = a;
    bus.b     = b;
    bus.wen   = wen_in;
    bus.kill  = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.wen   = 2'b00;
    bus.a     = $urandom;
    bus.b     = $urandom;
    for (int k = 1; k <= int'(lat); k++) begin
      check("busy_run", {31'b0, bus.busy}, 32'd1);
      check_hilo("old_hilo", oh, ol);
      if (k == 2) begin
        case (disturb)
          1: begin bus.start = 1'b1; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom; end
          2: begin bus.wen = 2'b11; bus.a = $urandom; end
          3: bus.kill = 1'b1;
          default: ;
        endcase
      end else if (k == 3) begin
        bus.start = 1'b0;
        bus.wen   = 2'b00;
        bus.kill  = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_done", {31'b0, bus.busy}, 32'd0);
    model_op(op, a, b);
    check_hilo("commit", m_hi, m_lo);
  endtask

  task automatic move_to(input logic [1:0] wen, input logic [31:0] data, input logic kill);
    @(negedge clk);
    bus.wen  = wen;
    bus.a    = data;
    bus.kill = kill;
    @(negedge clk);
    bus.wen  = 2'b00;
    bus.kill = 1'b0;
    if (!kill) begin
      if (wen[1]) m_hi = data;
      if (wen[0]) m_lo = data;
    end
    check("mt_busy", {31'b0, bus.busy}, 32'd0);
    check_hilo("mt", m_hi, m_lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.wen    = '0;
    bus.ressrc = '0;
    bus.a      = '0;
    bus.b      = '0;
    bus.kill   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_res_none", bus.res, 32'd0);
    check_hilo("rst", 32'd0, 32'd0);
    reset = 1'b0;

    // Directed cases with fixed expected values
    do_op(MUDV_MULT, 32'hFFFF_FFFD, 32'd5, 2'b00, 0);
    check_hilo("mult_c", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_op(MUDV_MULTU, 32'hFFFF_FFFD, 32'd5, 2'b00, 0);
    check_hilo("multu_c", 32'h0000_0004, 32'hFFFF_FFF1);
    do_op(MUDV_DIVU, 32'd100, 32'd7, 2'b00, 0);
    check_hilo("divu_c", 32'd2, 32'd14);
    do_op(MUDV_DIV, 32'hFFFF_FFF9, 32'd2, 2'b00, 0);
    check_hilo("div_c", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(MUDV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 0);
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);
    do_op(MUDV_DIVU, 32'd9, 32'd0, 2'b00, 0);
`ifdef MUDV_DIVZERO_HOLD_EN
    check_hilo("divz", 32'd0, 32'h8000_0000);
`else
    check_hilo("divz", 32'd9, 32'hFFFF_FFFF);
`endif
    move_to(2'b10, 32'h0000_1234, 1'b0);
    check_hilo("mthi_c", 32'h0000_1234, m_lo);
    move_to(2'b01, 32'hCAFE_0001, 1'b1);
    move_to(2'b11, 32'h5555_AAAA, 1'b0);

    // start+wen together, wen during busy, second start, kill mid-op
    do_op(MUDV_MULT, 32'h0001_0003, 32'hFFFF_0007, 2'b11, 2);
    do_op(MUDV_DIV, 32'h7FFF_1234, 32'hFFFF_FF10, 2'b00, 1);
    do_op(MUDV_MULTU, 32'hDEAD_BEEF, 32'h1357_9BDF, 2'b00, 3);

    // Killed start: no busy, no state change, wen also suppressed
    @(negedge clk);
    bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'b010;
    bus.a = 32'h1111_2222; bus.b = 32'd3; bus.wen = 2'b11;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0; bus.wen = 2'b00;
    check("kill_busy", {31'b0, bus.busy}, 32'd0);
    check_hilo("kill", m_hi, m_lo);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        move_to(2'($urandom), $urandom, 1'($urandom_range(0, 1)));
      do_op(rop, ra, rb, 2'($urandom), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in busy cycle 4 aborts the op
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    #2 reset = 1'b1;
    #1 check("arst_busy", {31'b0, bus.busy}, 32'd0);
    m_hi = '0;
    m_lo = '0;
    check_hilo("arst", m_hi, m_lo);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < int'(DIV_LAT) + 2; k++) begin
      check("post_rst_busy", {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
    end
    check_hilo("post_rst", m_hi, m_lo);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
